atm_keypad_entry: RTL

- Keypad front-end that turns single-key events into a complete login request for the ATM core.
- Assembles a 4-digit decimal account number and a 1-digit PIN.
- Presents them on a valid/ack handshake and waits for the authentication verdict.
- Enforces an inactivity timeout and locks out after repeated failed logins. Sits between the physical keypad scanner and the ATM/authentication logic.

---
 rtl/atm_keypad_entry.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/atm_keypad_entry.sv
// Keypad front-end for the ATM: builds a 4-digit account number and a 1-digit PIN from key
// strobes, issues a login request, tracks the verdict, and enforces inactivity timeout and lockout.
module atm_keypad_entry #(
  parameter int ACC_DIGITS  = 4,
  parameter int MAX_TRIES   = 3,
  parameter int IDLE_CYCLES = 1000,
  parameter int LOCK_CYCLES = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        req_valid,
  input  logic        req_ack,
  output logic [11:0] acc_number,
  output logic [3:0]  pin,
  input  logic        resp_valid,
  input  logic        resp_ok,
  output logic [2:0]  digit_count,
  output logic        in_pin,
  output logic        logged_in,
  output logic        locked,
  output logic        err,
  output logic        timeout,
  output logic [2:0]  dbg_state
);

  // Handshake: req_valid rises the cycle after enter is accepted in PIN_ENTRY and stays high,
  // with acc_number/pin frozen, until req_ack is sampled high; resp_valid counts only in WAIT_RESP.
  typedef enum logic [2:0] {
    S_ACC_ENTRY = 3'd0,
    S_PIN_ENTRY = 3'd1,
    S_REQUEST   = 3'd2,
    S_WAIT_RESP = 3'd3,
    S_SESSION   = 3'd4,
    S_LOCKED    = 3'd5
  } state_t;

  localparam int IDLE_W = $clog2(IDLE_CYCLES);
  localparam int LOCK_W = $clog2(LOCK_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [2:0] ACC_N   = 3'(ACC_DIGITS);
  localparam logic [2:0] TRIES_N = 3'(MAX_TRIES);
  localparam logic [3:0] KEY_BS     = 4'hA;
  localparam logic [3:0] KEY_ENTER  = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;

  state_t            state_q, state_d;
  logic [11:0]       acc_q, acc_d;
  logic [3:0]        pin_q, pin_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        fail_q, fail_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [LOCK_W-1:0] lock_q, lock_d;
  logic              err_q, err_d;
  logic              to_q, to_d;
  logic              clr;
  logic              is_digit;
  logic [15:0]       acc_x;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    pin_d    = pin_q;
    cnt_d    = cnt_q;
    fail_d   = fail_q;
    idle_d   = '0;
    lock_d   = '0;
    err_d    = 1'b0;
    to_d     = 1'b0;
    clr      = 1'b0;
    is_digit = (key_code <= 4'd9);
    // Only evaluated while fewer than ACC_DIGITS digits are held, so acc_q <= 999 here.
    acc_x    = {4'd0, acc_q} * 16'd10 + {12'd0, key_code};

    case (state_q)
      S_ACC_ENTRY: begin
        if (key_valid) begin
          if (is_digit) begin
            if (cnt_q >= ACC_N || acc_x > 16'd4095) begin
              err_d = 1'b1;
            end else begin
              acc_d = acc_x[11:0];
              cnt_d = cnt_q + 3'd1;
            end
          end else if (key_code == KEY_BS) begin
            if (cnt_q != 3'd0) begin
              acc_d = acc_q / 12'd10;
              cnt_d = cnt_q - 3'd1;
            end
          end else if (key_code == KEY_ENTER) begin
            if (cnt_q == ACC_N) begin
              state_d = S_PIN_ENTRY;
              cnt_d   = 3'd0;
            end else begin
              err_d = 1'b1;
            end
          end else if (key_code == KEY_CANCEL) begin
            clr = 1'b1;
          end
        end else if (cnt_q != 3'd0 || acc_q != 12'd0) begin
          if (idle_q == IDLE_LAST) begin
            to_d = 1'b1;
            clr  = 1'b1;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end

      S_PIN_ENTRY: begin
        if (key_valid) begin
          if (is_digit) begin
            if (cnt_q == 3'd0) begin
              pin_d = key_code;
              cnt_d = 3'd1;
            end else begin
              err_d = 1'b1;
            end
          end else if (key_code == KEY_BS) begin
            pin_d = 4'd0;
            cnt_d = 3'd0;
          end else if (key_code == KEY_ENTER) begin
            if (cnt_q == 3'd1) state_d = S_REQUEST;
            else               err_d   = 1'b1;
          end else if (key_code == KEY_CANCEL) begin
            clr = 1'b1;
          end
        end else if (idle_q == IDLE_LAST) begin
          to_d = 1'b1;
          clr  = 1'b1;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end

      S_REQUEST: begin
        if (req_ack) state_d = S_WAIT_RESP;
      end

      S_WAIT_RESP: begin
        if (resp_valid) begin
          if (resp_ok) begin
            state_d = S_SESSION;
            fail_d  = 3'd0;
          end else begin
            fail_d = fail_q + 3'd1;
            err_d  = 1'b1;
            clr    = 1'b1;
          end
        end
      end

      S_SESSION: begin
        if (key_valid && key_code == KEY_CANCEL) clr = 1'b1;
      end

      S_LOCKED: begin
        if (lock_q == LOCK_LAST) begin
          state_d = S_ACC_ENTRY;
          fail_d  = 3'd0;
        end else begin
          lock_d = lock_q + 1'b1;
        end
      end

      default: clr = 1'b1;
    endcase

    if (clr) begin
      state_d = S_ACC_ENTRY;
      acc_d   = 12'd0;
      pin_d   = 4'd0;
      cnt_d   = 3'd0;
    end
    // A failed verdict that exhausts the tries overrides the return to ACC_ENTRY.
    if (state_q == S_WAIT_RESP && resp_valid && !resp_ok && fail_d == TRIES_N) begin
      state_d = S_LOCKED;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_ACC_ENTRY;
      acc_q   <= 12'd0;
      pin_q   <= 4'd0;
      cnt_q   <= 3'd0;
      fail_q  <= 3'd0;
      idle_q  <= '0;
      lock_q  <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      pin_q   <= pin_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      idle_q  <= idle_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  assign req_valid   = (state_q == S_REQUEST);
  assign in_pin      = (state_q == S_PIN_ENTRY);
  assign logged_in   = (state_q == S_SESSION);
  assign locked      = (state_q == S_LOCKED);
  assign acc_number  = acc_q;
  assign pin         = pin_q;
  assign digit_count = cnt_q;
  assign err         = err_q;
  assign timeout     = to_q;
  assign dbg_state   = state_q;

endmodule
